pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 16 +
 rtl/sat_counter.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 89 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline types: per-register bubble control and the hazard sequencer state.
package pipeline_hazard_ctrl_pkg;

  // Synchronous clear request for a pipeline register (RESET_RESET inserts a bubble).
  typedef enum logic {
    RESET_CONTINUE = 1'b0,
    RESET_RESET    = 1'b1
  } reset_t;

  // ST_REDIR: a redirect was taken while a wrong-path fetch was still outstanding.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REDIR = 2'd1
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low clear
//   inc_i    count one when high
//   value_o  current count; sticks at all-ones
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//   clk, reset (async, active-low)
//   Iwait, Dwait, exe_is_waiting, load_use_D, branch_taken_E : hazard events
//   stall_PC, stall_IF_ID                                      : hold controls
//   reset_IF_ID/ID_EX/EX_MEM/MEM_WB                            : bubble controls
//   redirect_pending                                           : wrong-path fetch still in flight
//   stall_cycles                                               : saturating frozen/bubbled count
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Iwait,
  input  logic             Dwait,
  input  logic             exe_is_waiting,
  input  logic             load_use_D,
  input  logic             branch_taken_E,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output reset_t           reset_IF_ID,
  output reset_t           reset_ID_EX,
  output reset_t           reset_EX_MEM,
  output reset_t           reset_MEM_WB,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] stall_cycles
);

  hz_state_t state_q, state_d;
  logic      freeze;
  logic      stall_inc;

  always_comb begin
    freeze           = Dwait | exe_is_waiting;
    state_d          = state_q;
    stall_PC         = 1'b0;
    stall_IF_ID      = 1'b0;
    reset_IF_ID      = RESET_CONTINUE;
    reset_ID_EX      = RESET_CONTINUE;
    reset_EX_MEM     = RESET_CONTINUE;
    reset_MEM_WB     = RESET_CONTINUE;
    redirect_pending = reset && (state_q == ST_REDIR);

    if (!reset) begin
      reset_IF_ID  = RESET_RESET;
      reset_ID_EX  = RESET_RESET;
      reset_EX_MEM = RESET_RESET;
      reset_MEM_WB = RESET_RESET;
      state_d      = ST_RUN;
    end else if (freeze) begin
      // Whole front end holds; EX keeps any branch so it is re-presented afterwards.
      stall_PC    = 1'b1;
      stall_IF_ID = 1'b1;
    end else if (branch_taken_E) begin
      reset_IF_ID = RESET_RESET;
      reset_ID_EX = RESET_RESET;
      state_d     = Iwait ? ST_REDIR : ST_RUN;
    end else if ((state_q == ST_REDIR) && !Iwait) begin
      // Wrong-path word lands now: drop it while the redirected PC issues.
      reset_IF_ID = RESET_RESET;
      state_d     = ST_RUN;
    end else if (load_use_D || Iwait) begin
      stall_PC    = 1'b1;
      stall_IF_ID = 1'b1;
      reset_ID_EX = RESET_RESET;
    end

    stall_inc = reset & (freeze | stall_PC | (reset_ID_EX == RESET_RESET));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .inc_i  (stall_inc),
    .value_o(stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic Iwait = 1'b0, Dwait = 1'b0, exe_is_waiting = 1'b0, load_use_D = 1'b0;
  logic branch_taken_E = 1'b0;

  logic        stall_PC, stall_IF_ID, redirect_pending;
  reset_t      reset_IF_ID, reset_ID_EX, reset_EX_MEM, reset_MEM_WB;
  logic [31:0] stall_cycles;

  logic        s4_pc, s4_if, rp4;
  reset_t      r4_if, r4_id, r4_ex, r4_mw;
  logic [3:0]  cnt4;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: "a wrong-path fetch is outstanding" and total stall count.
  bit              m_redir = 1'b0;
  longint unsigned m_cnt   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .Iwait           (Iwait),
    .Dwait           (Dwait),
    .exe_is_waiting  (exe_is_waiting),
    .load_use_D      (load_use_D),
    .branch_taken_E  (branch_taken_E),
    .stall_PC        (stall_PC),
    .stall_IF_ID     (stall_IF_ID),
    .reset_IF_ID     (reset_IF_ID),
    .reset_ID_EX     (reset_ID_EX),
    .reset_EX_MEM    (reset_EX_MEM),
    .reset_MEM_WB    (reset_MEM_WB),
    .redirect_pending(redirect_pending),
    .stall_cycles    (stall_cycles)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk             (clk),
    .reset           (reset),
    .Iwait           (Iwait),
    .Dwait           (Dwait),
    .exe_is_waiting  (exe_is_waiting),
    .load_use_D      (load_use_D),
    .branch_taken_E  (branch_taken_E),
    .stall_PC        (s4_pc),
    .stall_IF_ID     (s4_if),
    .reset_IF_ID     (r4_if),
    .reset_ID_EX     (r4_id),
    .reset_EX_MEM    (r4_ex),
    .reset_MEM_WB    (r4_mw),
    .redirect_pending(rp4),
    .stall_cycles    (cnt4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, then advance the reference model.
  task automatic cyc(input bit r, input bit dw, input bit ex, input bit lu, input bit br,
                     input bit iw);
    bit freeze, s_pc, s_if, r_if, r_id, r_ex, r_mw, pend, nredir, inc;
    longint unsigned sat4;
    reset = r; Dwait = dw; exe_is_waiting = ex; load_use_D = lu; branch_taken_E = br; Iwait = iw;
    if (!r) begin
      m_redir = 1'b0;
      m_cnt   = 0;
    end
    #4;
    freeze = dw | ex;
    {s_pc, s_if, r_if, r_id, r_ex, r_mw} = '0;
    nredir = m_redir;
    if (!r) begin
      {r_if, r_id, r_ex, r_mw} = 4'b1111;
      nredir = 1'b0;
    end else if (freeze) begin
      {s_pc, s_if} = 2'b11;
    end else if (br) begin
      {r_if, r_id} = 2'b11;
      nredir = iw;
    end else if (m_redir && !iw) begin
      r_if   = 1'b1;
      nredir = 1'b0;
    end else if (lu || iw) begin
      {s_pc, s_if, r_id} = 3'b111;
    end
    pend = r & m_redir;
    inc  = r & (freeze | s_pc | r_id);
    sat4 = (m_cnt > 15) ? 15 : m_cnt;

    check_eq("stall_PC",         64'(stall_PC), 64'(s_pc));
    check_eq("stall_IF_ID",      64'(stall_IF_ID), 64'(s_if));
    check_eq("reset_IF_ID",      64'(reset_IF_ID == RESET_RESET), 64'(r_if));
    check_eq("reset_ID_EX",      64'(reset_ID_EX == RESET_RESET), 64'(r_id));
    check_eq("reset_EX_MEM",     64'(reset_EX_MEM == RESET_RESET), 64'(r_ex));
    check_eq("reset_MEM_WB",     64'(reset_MEM_WB == RESET_RESET), 64'(r_mw));
    check_eq("redirect_pending", 64'(redirect_pending), 64'(pend));
    check_eq("stall_cycles",     64'(stall_cycles), m_cnt);
    check_eq("w4_outputs",
             64'({s4_pc, s4_if, r4_if == RESET_RESET, r4_id == RESET_RESET,
                  r4_ex == RESET_RESET, r4_mw == RESET_RESET, rp4}),
             64'({s_pc, s_if, r_if, r_id, r_ex, r_mw, pend}));
    check_eq("w4_stall_cycles",  64'(cnt4), sat4);

    @(posedge clk);
    if (r) begin
      m_redir = nredir;
      if (inc) m_cnt++;
    end
    #1;
  endtask

  initial begin
    // Reset held three cycles, then released idle.
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Single load-use bubble.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Redirect with fetch in flight, Iwait held three more cycles, then the squash.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // D-mem freeze masks a pending branch and load-use; branch flushes afterwards.
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Multicycle EX freeze in ST_REDIR while Iwait falls: squash deferred.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Long freeze from a clean counter: narrow instance saturates at 15.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Randomized traffic with occasional async reset.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(199) != 0,
          $urandom_range(9) == 0,
          $urandom_range(12) == 0,
          $urandom_range(6) == 0,
          $urandom_range(6) == 0,
          $urandom_range(4) < 2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
